// File: rtl/fifo_unit.sv
// ============================================================================
// Module   : fifo_unit
// Brief    : Synchronous ready/valid FIFO with global enable and zero-masked
//            head output. Optional occupancy port via FIFO_UNIT_LEVEL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FIFO_UNIT_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    // Full refuses a push even when a pop would free a slot this cycle.
    assign in_ready  = en && (r_count < C_FULL);
    assign out_valid = en && (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;

    assign w_push = en && in_valid && in_ready;
    assign w_pop  = en && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never reset; the empty mask on out_data hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

`ifdef FIFO_UNIT_LEVEL_EN
    assign level = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_unit.sv
// ============================================================================
// Module   : tb_fifo_unit
// Brief    : Directed vector-table bench for fifo_unit (WIDTH=32, DEPTH=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
`ifdef FIFO_UNIT_LEVEL_EN
    logic [2:0]       level;
`endif

    int total;
    int bad;

    fifo_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FIFO_UNIT_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs are those seen with the inputs applied, before the edge.
    typedef struct {
        logic        rst;
        logic        en;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic iv, input logic [31:0] d, input logic o);
        @(negedge clk);
        rst       = r;
        en        = e;
        in_valid  = iv;
        in_data   = d;
        out_ready = o;
        #1;
    endtask

    task automatic check_level(input string name, input logic [2:0] exp);
`ifdef FIFO_UNIT_LEVEL_EN
        check(name, {61'd0, level}, {61'd0, exp});
`else
        if (exp === 3'bxxx) $display("unused level %0d", exp);
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        //               rst  en   iv   d        or   ir   ov   od      lvl
        // fill, full with simultaneous pop, drain, empty pop
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b0,1'b1,1'b0,32'h00,3'd0});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h11,1'b0,1'b1,1'b0,32'h00,3'd0});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h22,1'b0,1'b1,1'b1,32'h11,3'd1});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h33,1'b0,1'b1,1'b1,32'h11,3'd2});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h44,1'b0,1'b1,1'b1,32'h11,3'd3});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h55,1'b1,1'b0,1'b1,32'h11,3'd4});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b0,1'b1,1'b1,32'h22,3'd3});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h66,1'b0,1'b1,1'b1,32'h22,3'd3});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b0,1'b1,32'h22,3'd4});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b1,32'h33,3'd3});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b1,32'h44,3'd2});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b1,32'h66,3'd1});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b0,32'h00,3'd0});
        // enable hold with two entries
        vecs.push_back('{1'b0,1'b1,1'b1,32'h0A,1'b0,1'b1,1'b0,32'h00,3'd0});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h0B,1'b0,1'b1,1'b1,32'h0A,3'd1});
        for (int k = 0; k < 5; k++)
            vecs.push_back('{1'b0,1'b0,1'b1,32'h0C,1'b1,1'b0,1'b0,32'h00,3'd2});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b0,1'b1,1'b1,32'h0A,3'd2});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b1,32'h0A,3'd2});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b1,32'h0B,3'd1});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b0,1'b1,1'b0,32'h00,3'd0});
        // reset mid-operation with a coincident push
        vecs.push_back('{1'b0,1'b1,1'b1,32'h01,1'b0,1'b1,1'b0,32'h00,3'd0});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h02,1'b0,1'b1,1'b1,32'h01,3'd1});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h03,1'b0,1'b1,1'b1,32'h01,3'd2});
        vecs.push_back('{1'b1,1'b1,1'b1,32'h04,1'b0,1'b1,1'b1,32'h01,3'd3});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h05,1'b0,1'b1,1'b0,32'h00,3'd0});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b0,1'b1,1'b1,32'h05,3'd1});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b1,32'h05,3'd1});
        vecs.push_back('{1'b0,1'b1,1'b0,32'h00,1'b1,1'b1,1'b0,32'h00,3'd0});

        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check($sformatf("v%0d in_ready", i),  {63'd0, in_ready},  {63'd0, vecs[i].e_ir});
            check($sformatf("v%0d out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
            check($sformatf("v%0d out_data", i),  {32'd0, out_data},  {32'd0, vecs[i].e_od});
            check_level($sformatf("v%0d level", i), vecs[i].e_lvl);
        end

        // Streaming push/pop across pointer wrap: one word in flight.
        for (int i = 0; i <= 20; i++) begin
            drive(1'b0, 1'b1, (i < 20), 32'(i), 1'b1);
            check($sformatf("s%0d in_ready", i), {63'd0, in_ready}, 64'd1);
            if (i == 0) begin
                check("s0 out_valid", {63'd0, out_valid}, 64'd0);
                check_level("s0 level", 3'd0);
            end else begin
                check($sformatf("s%0d out_valid", i), {63'd0, out_valid}, 64'd1);
                check($sformatf("s%0d out_data", i), {32'd0, out_data}, 64'(i - 1));
                check_level($sformatf("s%0d level", i), 3'd1);
            end
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check("stream end out_valid", {63'd0, out_valid}, 64'd0);
        check("stream end out_data", {32'd0, out_data}, 64'd0);

        // Refill to full after the earlier reset: exactly DEPTH pushes fit.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'hA0 + 32'(i), 1'b0);
            check($sformatf("refill%0d in_ready", i), {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 1'b1, 1'b1, 32'hFF, 1'b0);
        check("refill full in_ready", {63'd0, in_ready}, 64'd0);
        check("refill full head", {32'd0, out_data}, 64'hA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_unit.md
FIFO_UNIT -- requirements
Module: fifo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  global enable; 0 freezes all state.
REQ-006 SHALL have port in_data  input  WIDTH  write word.
REQ-007 SHALL have port in_valid  input  1  producer offers in_data.
REQ-008 SHALL have port in_ready  output  1  FIFO accepts a word this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  head-of-queue word.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data.

Function
REQ-012 SHALL perform a push on a rising edge when en=1, in_valid=1 and in_ready=1.
REQ-013 SHALL perform a pop on a rising edge when en=1, out_valid=1 and out_ready=1.
REQ-014 SHALL drive in_ready = en AND (count < DEPTH); in_ready SHALL NOT depend on out_ready.
REQ-015 SHALL drive out_valid = en AND (count > 0).
REQ-016 SHALL drive out_data = entry at read pointer when out_valid=1, else all zeros.
REQ-017 SHALL give push-to-visible latency of exactly 1 cycle: word pushed at edge N is on out_data with out_valid=1 after edge N when the FIFO was empty before edge N.
REQ-018 SHALL preserve strict FIFO order; no word duplicated or dropped.
REQ-019 SHALL use log2(DEPTH)-bit read/write pointers that wrap from DEPTH-1 to 0, plus a count register of log2(DEPTH)+1 bits.
REQ-020 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-021 SHALL, when full, refuse the push even if a pop occurs the same cycle (in_ready=0 at full).
REQ-022 SHALL, when empty, ignore out_ready (out_valid=0, no pop).
REQ-023 SHALL, with en=0, hold pointers, count and storage unchanged regardless of in_valid/out_ready.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, clear read pointer, write pointer and count to 0, giving in_ready=en, out_valid=0, out_data=0 the following cycle.
REQ-025 SHALL give rst priority over en, push and pop; a push coincident with rst SHALL be discarded.
REQ-026 SHALL NOT clear storage entries on reset; stale contents SHALL never be observable because out_data is zero-masked when empty.

Configuration
REQ-027 SHALL, when macro FIFO_UNIT_LEVEL_EN is defined, add output port level (log2(DEPTH)+1 bits) equal to the current count register, reset to 0.
REQ-028 SHALL, when FIFO_UNIT_LEVEL_EN is undefined, omit the level port entirely with all other behaviour identical.

Verification
REQ-029 SHALL cover fill/drain: WIDTH=32, DEPTH=4, en=1, push 0x11,0x22,0x33,0x44 with out_ready=0 -> in_ready=0 after 4th push; then out_ready=1 -> 0x11..0x44 in order, out_valid=0 after 4 pops.
REQ-030 SHALL cover full with simultaneous pop: FIFO full, in_valid=1 in_data=0x55, out_ready=1 for one cycle -> 0x11 popped, 0x55 not written, count=3, in_ready=1 next cycle.
REQ-031 SHALL cover streaming with wrap: continuous push/pop of 0..19 for 20 cycles -> count stays 1 after first cycle, outputs 0..19 in order with 1-cycle latency across pointer wrap.
REQ-032 SHALL cover enable hold: 2 entries (0xA,0xB), en=0 for 5 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, out_data=0; en=1 -> out_data=0xA, count=2.
REQ-033 SHALL cover reset mid-operation: 3 entries, assert rst one cycle with in_valid=1 -> next cycle out_valid=0, out_data=0, count (level when FIFO_UNIT_LEVEL_EN) =0; next push appears on out_data after 1 cycle.
